// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
// Shared router definitions for the output-port switch arbiter:
//   - log2 : ceiling log2, used to size credit counters and pointers
//   - CNTw : credit counter width for the default buffer depth of 4 flits
//   - lock_state_e : IDLE / LOCKED encoding of the output-port lock FSM
// ----------------------------------------------------------------------------
package router_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Smallest w such that 2**w >= value (value 1 gives 0).
  function automatic int log2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int B_DEFAULT = 4;
  localparam int CNTw      = log2(B_DEFAULT + 1);

endpackage

// File: rtl/out_port_sw_arbiter_if.sv
// ----------------------------------------------------------------------------
// out_port_sw_arbiter_if
// Bundle between the input-port request logic / downstream credit return and
// one output-port switch arbiter.
//   req, req_ovc, req_hdr, req_tail : per-requester flit requests (N = P-1)
//   credit_in                       : one credit per OVC returned downstream
//   grant, grant_q, flit_we_q       : combinational and registered grants
//   ovc_credit_ok, locked, err      : status
// Modports: slave = arbiter side, master = requester/crossbar side.
// ----------------------------------------------------------------------------
interface out_port_sw_arbiter_if #(
  parameter int P = 5,
  parameter int V = 2
);
  localparam int N = P - 1;

  logic [N-1:0]   req;
  logic [N*V-1:0] req_ovc;
  logic [N-1:0]   req_hdr;
  logic [N-1:0]   req_tail;
  logic [V-1:0]   credit_in;
  logic [N-1:0]   grant;
  logic [N-1:0]   grant_q;
  logic           flit_we_q;
  logic [V-1:0]   ovc_credit_ok;
  logic           locked;
  logic           err;

  modport slave (
    input  req, req_ovc, req_hdr, req_tail, credit_in,
    output grant, grant_q, flit_we_q, ovc_credit_ok, locked, err
  );

  modport master (
    output req, req_ovc, req_hdr, req_tail, credit_in,
    input  grant, grant_q, flit_we_q, ovc_credit_ok, locked, err
  );

endinterface

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational one-hot round-robin pick. Priority starts at i_ptr and wraps
// from N-1 back to 0.
//   i_req    : request vector
//   i_ptr    : index with highest priority this cycle
//   o_grant  : one-hot winner (0 when no request)
//   o_winner : winner index
//   o_valid  : some request won
// ----------------------------------------------------------------------------
module rr_arbiter
  import router_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? log2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_winner,
  output logic          o_valid
);

  // Two ordered scans: first the indices at or above the pointer, then the
  // ones below it. This realises the wrap without a variable-index modulo.
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!o_valid && i_req[i] && (i >= int'(i_ptr))) begin
        o_valid    = 1'b1;
        o_grant[i] = 1'b1;
        o_winner   = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!o_valid && i_req[i] && (i < int'(i_ptr))) begin
        o_valid    = 1'b1;
        o_grant[i] = 1'b1;
        o_winner   = PW'(i);
      end
    end
  end

endmodule

// File: rtl/out_port_sw_arbiter.sv
// ----------------------------------------------------------------------------
// out_port_sw_arbiter
// Switch arbiter and credit scheduler for one router output port. Grants at
// most one flit per cycle among the P-1 other input ports, only when the
// target output VC holds a downstream credit, and keeps the port locked to one
// input for the duration of a multi-flit packet. The registered grant drives
// the crossbar column select one cycle later.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : out_port_sw_arbiter_if.slave (requests, credits, grants,
//                status)
// Configuration macro SW_ARB_CHECK_EN: when defined, err latches on credit
// overflow, a non-one-hot OVC request, a head flit from the lock owner while
// locked, or a body flit while idle. When undefined err is 0 and credit
// overflow saturates silently.
// ----------------------------------------------------------------------------
module out_port_sw_arbiter
  import router_pkg::*;
#(
  parameter int V = 2,
  parameter int P = 5,
  parameter int B = 4
) (
  input logic                  clk,
  input logic                  reset,
  out_port_sw_arbiter_if.slave bus
);

  localparam int N        = P - 1;
  localparam int CREDIT_W = log2(B + 1);
  localparam int PTR_W    = (N > 1) ? log2(N) : 1;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(B);

  lock_state_e         r_state;
  lock_state_e         w_stateNext;
  logic [PTR_W-1:0]    r_lockId;
  logic [PTR_W-1:0]    w_lockIdNext;
  logic [PTR_W-1:0]    r_rrPtr;
  logic [CREDIT_W-1:0] r_credit [V];
  logic [V-1:0]        w_creditOk;
  logic [V-1:0]        w_winOvc;
  logic [V-1:0]        w_dec;
  logic [V-1:0]        w_inc;
  logic [N-1:0]        w_elig;
  logic [N-1:0]        w_grant;
  logic [N-1:0]        r_grantQ;
  logic                r_flitWe;
  logic [PTR_W-1:0]    w_winner;
  logic                w_grantValid;
  logic                w_winHdr;
  logic                w_winTail;

  // A VC is usable whenever its credit counter is non-zero.
  always_comb begin
    w_creditOk = '0;
    for (int v = 0; v < V; v++) begin
      w_creditOk[v] = (r_credit[v] != '0);
    end
  end

  // A requester is eligible if its target OVC has credit and either the port
  // is free or it is the current lock owner.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N; i++) begin
      w_elig[i] = bus.req[i]
                & (|(bus.req_ovc[i*V +: V] & w_creditOk))
                & ((r_state == IDLE) | (r_lockId == PTR_W'(i)));
    end
  end

  rr_arbiter #(
    .N  (N),
    .PW (PTR_W)
  ) u_rrArbiter (
    .i_req    (w_elig),
    .i_ptr    (r_rrPtr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_valid  (w_grantValid)
  );

  // Pull the winner's OVC and flit type out of the request bundle; the grant
  // is one-hot so OR-ing the masked slices yields exactly the winner's.
  always_comb begin
    w_winOvc = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_winOvc = bus.req_ovc[i*V +: V];
      end
    end
    w_winHdr  = |(w_grant & bus.req_hdr);
    w_winTail = |(w_grant & bus.req_tail);
    w_dec     = w_winOvc & w_creditOk;
    w_inc     = bus.credit_in;
  end

  // Credit counters: simultaneous return and consume cancel out, a return at
  // full credit saturates, and consumption cannot underflow since a grant
  // only happens on a non-zero counter.
  always_ff @(posedge clk) begin
    for (int v = 0; v < V; v++) begin
      if (reset) begin
        r_credit[v] <= CREDIT_MAX;
      end else begin
        case ({w_inc[v], w_dec[v]})
          2'b01:   r_credit[v] <= r_credit[v] - 1'b1;
          2'b10:   if (r_credit[v] != CREDIT_MAX) r_credit[v] <= r_credit[v] + 1'b1;
          default: r_credit[v] <= r_credit[v];
        endcase
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_lockId <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_lockId <= w_lockIdNext;
    end
  end

  // Lock FSM next state: a granted multi-flit head locks the port to its
  // sender; the owner's granted tail releases it. Single-flit packets never
  // lock.
  always_comb begin
    w_stateNext  = r_state;
    w_lockIdNext = r_lockId;
    case (r_state)
      IDLE: begin
        if (w_grantValid && w_winHdr && !w_winTail) begin
          w_stateNext  = LOCKED;
          w_lockIdNext = w_winner;
        end
      end
      LOCKED: begin
        if (w_grantValid && w_winTail) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Round-robin pointer moves just past the winner, and only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rrPtr <= '0;
    end else if (w_grantValid) begin
      r_rrPtr <= (w_winner == PTR_W'(N - 1)) ? '0 : w_winner + 1'b1;
    end
  end

  // Registered crossbar select and write enable, one cycle behind the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grantQ <= '0;
      r_flitWe <= 1'b0;
    end else begin
      r_grantQ <= w_grant;
      r_flitWe <= |w_grant;
    end
  end

  assign bus.grant         = w_grant;
  assign bus.grant_q       = r_grantQ;
  assign bus.flit_we_q     = r_flitWe;
  assign bus.ovc_credit_ok = w_creditOk;
  assign bus.locked        = (r_state == LOCKED);

`ifdef SW_ARB_CHECK_EN
  logic           r_err;
  logic           w_errEvent;
  logic [V-1:0]   w_slice;

  // Protocol checker: any of the four illegal conditions in a cycle raises
  // an error event.
  always_comb begin
    w_errEvent = 1'b0;
    w_slice    = '0;
    for (int v = 0; v < V; v++) begin
      if (w_inc[v] && !w_dec[v] && (r_credit[v] == CREDIT_MAX)) begin
        w_errEvent = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      w_slice = bus.req_ovc[i*V +: V];
      if (bus.req[i] && ((w_slice == '0) || ((w_slice & (w_slice - 1'b1)) != '0))) begin
        w_errEvent = 1'b1;
      end
      if (bus.req[i] && bus.req_hdr[i] && (r_state == LOCKED) && (r_lockId == PTR_W'(i))) begin
        w_errEvent = 1'b1;
      end
      if (bus.req[i] && !bus.req_hdr[i] && (r_state == IDLE)) begin
        w_errEvent = 1'b1;
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_errEvent) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule
